// File: rtl/gp_mem_initiator.sv
// Initiator engine: takes one generic-payload request at a time and runs it against a
// single-port synchronous memory. Partial-byte writes are done as read-modify-write.
module gp_mem_initiator #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned RD_LATENCY = 2,
    localparam int unsigned BE_W      = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_cmd_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [BE_W-1:0]   req_be_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [2:0]        rsp_status_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_q_i,
    output logic              end_sim_o
);

    localparam int unsigned CntW = $clog2(RD_LATENCY + 1);
    // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(MEM_DEPTH);

    localparam logic [1:0] CmdRead   = 2'd0;
    localparam logic [1:0] CmdWrite  = 2'd1;
    localparam logic [1:0] CmdIgnore = 2'd2;
    localparam logic [1:0] CmdEndSim = 2'd3;

    localparam logic [2:0] StatusOk      = 3'd1;
    localparam logic [2:0] StatusAddrErr = 3'd2;
    localparam logic [2:0] StatusBeErr   = 3'd4;

    typedef enum logic [2:0] {StIdle, StRdWait, StRmwWait, StWr, StRsp, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              we_q, we_d;
    logic              wr_phase_q, wr_phase_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]        rsp_status_q, rsp_status_d;
    logic              end_sim_q, end_sim_d;

    logic [DATA_W-1:0] be_mask;
    logic              addr_oor;

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < int'(BE_W); i++) begin
            be_mask[i*8 +: 8] = {8{be_q[i]}};
        end
    end

    assign addr_oor = {1'b0, req_addr_i} >= DepthW;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            we_q         <= 1'b0;
            wr_phase_q   <= 1'b0;
            data_q       <= '0;
            be_q         <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            end_sim_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            we_q         <= we_d;
            wr_phase_q   <= wr_phase_d;
            data_q       <= data_d;
            be_q         <= be_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            end_sim_q    <= end_sim_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        we_d         = 1'b0;
        wr_phase_d   = wr_phase_q;
        data_d       = data_q;
        be_d         = be_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        end_sim_d    = end_sim_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    data_d       = req_data_i;
                    be_d         = req_be_i;
                    rsp_data_d   = '0;
                    rsp_status_d = StatusOk;
                    if (req_cmd_i == CmdIgnore) begin
                        state_d = StRsp;
                    end else if (req_cmd_i == CmdEndSim) begin
                        state_d   = StRsp;
                        end_sim_d = 1'b1;
                    end else if (addr_oor) begin
                        state_d      = StRsp;
                        rsp_status_d = StatusAddrErr;
                    end else if (req_be_i == '0) begin
                        state_d      = StRsp;
                        rsp_status_d = StatusBeErr;
                    end else if (req_cmd_i == CmdRead) begin
                        state_d    = StRdWait;
                        mem_addr_d = req_addr_i;
                        cnt_d      = CntW'(RD_LATENCY);
                    end else if (&req_be_i) begin
                        state_d    = StWr;
                        mem_addr_d = req_addr_i;
                        mem_data_d = req_data_i;
                        we_d       = 1'b1;
                        wr_phase_d = 1'b0;
                    end else begin
                        state_d    = StRmwWait;
                        mem_addr_d = req_addr_i;
                        cnt_d      = CntW'(RD_LATENCY);
                    end
                end
            end
            StRdWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    rsp_data_d = mem_q_i & be_mask;
                    state_d    = StRsp;
                end
            end
            StRmwWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    mem_data_d = (data_q & be_mask) | (mem_q_i & ~be_mask);
                    we_d       = 1'b1;
                    wr_phase_d = 1'b0;
                    state_d    = StWr;
                end
            end
            StWr: begin
                // Strobe occupies the first WR cycle; the second lets the write settle.
                if (!wr_phase_q) begin
                    wr_phase_d = 1'b1;
                end else begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready_i) begin
                    state_d = end_sim_q ? StDone : StIdle;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == StIdle) && !rst_i;
        rsp_valid_o  = (state_q == StRsp);
        rsp_data_o   = rsp_data_q;
        rsp_status_o = rsp_status_q;
        mem_addr_o   = mem_addr_q;
        mem_data_o   = mem_data_q;
        mem_we_o     = we_q;
        end_sim_o    = end_sim_q;
    end

endmodule

// File: tb/tb_gp_mem_initiator.sv
// Scoreboard bench for gp_mem_initiator: directed scenarios plus randomized traffic
// checked against a word-level reference memory.
module tb_gp_mem_initiator;

    localparam int unsigned RdLat = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_cmd = 2'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_status;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic [31:0] mem_q;
    logic        end_sim;

    gp_mem_initiator #(
        .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256), .RD_LATENCY(RdLat)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(req_cmd),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_status_o(rsp_status), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .mem_we_o(mem_we), .mem_q_i(mem_q), .end_sim_o(end_sim)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int we_cycles = 0;
    int exp_we = 0;
    int rsp_count = 0;
    int hs_edge = 0;
    int bp_mode = 0;
    int ready_viol = 0;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  status;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [31:0] ref_mem [256];
    logic [31:0] ram [256];
    logic [31:0] stage1 = '0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    // Memory with RdLat=2 registered read path; preload port is bench-only.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) we_cycles <= we_cycles + 1;
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_we && mem_addr < 256) ram[mem_addr[7:0]] <= mem_data;
        stage1 <= (mem_addr < 256) ? ram[mem_addr[7:0]] : 32'h0;
        mem_q  <= stage1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        case (bp_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = ($urandom_range(0, 3) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    logic        mon_prev = 1'b0;
    int          mon_rise = 0;
    logic [31:0] mon_sd = '0;
    logic [2:0]  mon_ss = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev = 1'b0;
            end else begin
                if (rsp_valid && !mon_prev) begin
                    mon_rise = cyc;
                    mon_sd   = rsp_data;
                    mon_ss   = rsp_status;
                    rsp_count++;
                end
                if (rsp_valid && req_ready) ready_viol++;
                if (rsp_valid && rsp_ready) begin
                    hs_edge = cyc + 1;
                    check("rsp_stable_data", rsp_data, mon_sd);
                    check("rsp_stable_status", 32'(rsp_status), 32'(mon_ss));
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_rsp: actual=response required=none");
                    end else begin
                        e = sb.pop_front();
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_status", 32'(rsp_status), 32'(e.status));
                        if (e.lat >= 0) check("rsp_latency", 32'(mon_rise - e.acc), 32'(e.lat));
                    end
                end
                mon_prev = rsp_valid;
            end
        end
    end

    // Expected response and memory effect, straight from the command rules.
    task automatic model(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input int acc);
        exp_t        e;
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
        e.data = '0; e.status = 3'd1; e.acc = acc; e.lat = -1;
        if (cmd == 2'd2 || cmd == 2'd3) begin
            e.status = 3'd1;
        end else if (addr >= 256) begin
            e.status = 3'd2;
        end else if (be == 4'h0) begin
            e.status = 3'd4;
        end else if (cmd == 2'd0) begin
            e.data = ref_mem[addr[7:0]] & m;
            e.lat  = RdLat + 1;
        end else begin
            ref_mem[addr[7:0]] = (data & m) | (ref_mem[addr[7:0]] & ~m);
            exp_we++;
            e.lat = (be == 4'hF) ? 2 : RdLat + 3;
        end
        sb.push_back(e);
    endtask

    task automatic send(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input bit expect_rsp, output int acc);
        int waited;
        waited = 0;
        @(negedge clk);
        req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_data = data; req_be = be;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("req_accept", 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        if (expect_rsp) model(cmd, addr, data, be, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = 8'(a); pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    initial begin
        int          acc;
        int          n;
        int          viol;
        int          we0;
        int          rc0;
        logic [31:0] snap_d;
        logic [2:0]  snap_s;
        logic [1:0]  c;
        logic [31:0] a;
        logic [3:0]  b;

        repeat (3) @(negedge clk);
        check("ready_in_reset", 32'(req_ready), 32'd0);
        for (int i = 0; i < 256; i++) preload(i, $urandom);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_end_sim", 32'(end_sim), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_status", 32'(rsp_status), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);

        // T1 full write then read back
        send(2'd1, 32'd5, 32'hDEADBEEF, 4'hF, 1'b1, acc);
        drain();
        check("t1_ram5", ram[5], 32'hDEADBEEF);
        check("t1_we_cycles", 32'(we_cycles), 32'(exp_we));
        send(2'd0, 32'd5, 32'h0, 4'hF, 1'b1, acc);
        drain();

        // T2 partial write
        preload(7, 32'hAA001122);
        send(2'd1, 32'd7, 32'h33445566, 4'h5, 1'b1, acc);
        drain();
        check("t2_ram7", ram[7], 32'hAA441166);
        check("t2_we_cycles", 32'(we_cycles), 32'(exp_we));

        // T3 errors
        we0 = we_cycles;
        send(2'd0, 32'd256, 32'h0, 4'hF, 1'b1, acc);
        send(2'd1, 32'd3, 32'h12345678, 4'h0, 1'b1, acc);
        drain();
        check("t3_no_we", 32'(we_cycles), 32'(we0));
        check("t3_ram3", ram[3], ref_mem[3]);

        // T4 backpressure
        bp_mode = 2;
        repeat (2) @(negedge clk);
        send(2'd0, 32'd1, 32'h0, 4'hF, 1'b1, acc);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_rsp_rise", 32'(rsp_valid), 32'd1);
        snap_d = rsp_data;
        snap_s = rsp_status;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_data !== snap_d || rsp_status !== snap_s || req_ready !== 1'b0 || !rsp_valid)
                viol++;
        end
        check("t4_hold", 32'(viol), 32'd0);
        bp_mode = 0;
        send(2'd0, 32'd1, 32'h0, 4'hF, 1'b1, acc);
        check("t4_next_accept", 32'(acc - hs_edge), 32'd1);
        drain();

        // T5 reset during RMW_WAIT
        we0 = we_cycles;
        rc0 = rsp_count;
        send(2'd1, 32'd9, $urandom, 4'h6, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_ready", 32'(req_ready), 32'd1);
        repeat (10) @(negedge clk);
        check("t5_no_we", 32'(we_cycles), 32'(we0));
        check("t5_no_rsp", 32'(rsp_count), 32'(rc0));
        check("t5_ram9", ram[9], ref_mem[9]);

        // Randomized traffic with random backpressure
        bp_mode = 1;
        repeat (60) begin
            n = $urandom_range(0, 9);
            c = (n < 4) ? 2'd0 : (n < 8) ? 2'd1 : 2'd2;
            n = $urandom_range(0, 9);
            if (n < 6) a = $urandom_range(0, 15);
            else if (n < 8) a = $urandom_range(250, 261);
            else if (n == 8) a = 32'hFFFF_FF00 | $urandom_range(0, 15);
            else a = $urandom_range(0, 255);
            b = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            send(c, a, $urandom, b, 1'b1, acc);
        end
        drain();
        bp_mode = 0;
        repeat (2) @(negedge clk);
        check("rand_we_cycles", 32'(we_cycles), 32'(exp_we));
        for (int i = 0; i < 16; i++) check("rand_ram", ram[i], ref_mem[i]);
        for (int i = 248; i < 256; i++) check("rand_ram", ram[i], ref_mem[i]);
        check("ready_during_rsp", 32'(ready_viol), 32'd0);

        // T6 END_SIM
        check("t6_end_sim_before", 32'(end_sim), 32'd0);
        send(2'd3, $urandom, 32'h0, 4'h0, 1'b1, acc);
        check("t6_end_sim_at_a", 32'(end_sim), 32'd1);
        drain();
        repeat (5) @(negedge clk);
        check("t6_done_ready", 32'(req_ready), 32'd0);
        check("t6_done_end_sim", 32'(end_sim), 32'd1);
        check("t6_done_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_reset_end_sim", 32'(end_sim), 32'd0);
        check("t6_reset_ready", 32'(req_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
